// File: rtl/cia_serial_peer.sv
// cia_serial_peer: byte-wide peer for a CIA serial port.
// master=1: drives CNT/SP toward a CIA in serial-input mode (MSB first).
// master=0: samples CNT/SP from a CIA in serial-output mode.
module cia_serial_peer #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP         = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       master,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_timeout,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic       cnt_out,
  output logic       sp_out
);

  localparam int TMAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] HP_LAST  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP - 1);
  localparam logic [IW-1:0] TO_LAST  = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_GAP} tx_state_t;

  // synchronizers and CNT edge detector
  logic cnt_s1_q, cnt_s1_d, cnt_s2_q, cnt_s2_d, cnt_prev_q, cnt_prev_d;
  logic sp_s1_q, sp_s1_d, sp_s2_q, sp_s2_d;
  logic cnt_fall;

  // transmitter
  tx_state_t      state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_q, bit_d;
  logic           cnt_out_q, cnt_out_d, sp_out_q, sp_out_d;

  // receiver
  logic [7:0]     rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [2:0]     rx_bits_q, rx_bits_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic           rx_valid_q, rx_valid_d;
  logic           rx_overrun_q, rx_overrun_d, rx_timeout_q, rx_timeout_d;
  logic [7:0]     rx_next;

  // CNT and SP share the same two-stage depth so SP stays aligned to CNT edges
  always_comb begin
    cnt_s1_d   = cnt_in;
    cnt_s2_d   = cnt_s1_q;
    cnt_prev_d = cnt_s2_q;
    sp_s1_d    = sp_in;
    sp_s2_d    = sp_s1_q;
  end

  assign cnt_fall = cnt_prev_q & ~cnt_s2_q;

  // TX next-state: leaving master mode aborts any byte and idles both lines
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    cnt_out_d = cnt_out_q;
    sp_out_d  = sp_out_q;
    if (!master) begin
      state_d   = ST_IDLE;
      timer_d   = '0;
      bit_d     = 3'd0;
      cnt_out_d = 1'b1;
      sp_out_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            state_d   = ST_LOW;
            shift_d   = tx_data;
            bit_d     = 3'd0;
            timer_d   = '0;
            cnt_out_d = 1'b0;
            sp_out_d  = tx_data[7];
          end else begin
            cnt_out_d = 1'b1;
            sp_out_d  = 1'b1;
          end
        end
        ST_LOW: begin
          if (timer_q == HP_LAST) begin
            state_d   = ST_HIGH;
            timer_d   = '0;
            cnt_out_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_HIGH: begin
          if (timer_q == HP_LAST) begin
            timer_d = '0;
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
              cnt_out_d = 1'b1;
              sp_out_d  = 1'b1;
            end else begin
              state_d   = ST_LOW;
              cnt_out_d = 1'b0;
              sp_out_d  = shift_q[6];
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_GAP: begin
          if (timer_q == GAP_LAST) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          timer_d   = '0;
          cnt_out_d = 1'b1;
          sp_out_d  = 1'b1;
        end
      endcase
    end
  end

  // RX next-state: shift on CNT falls, deliver on the 8th, drop stale partial bytes
  always_comb begin
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_bits_d    = rx_bits_q;
    idle_d       = idle_q;
    rx_overrun_d = 1'b0;
    rx_timeout_d = 1'b0;
    rx_next      = {rx_shift_q[6:0], sp_s2_q};
    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    if (master) begin
      rx_bits_d = 3'd0;
      idle_d    = '0;
    end else if (cnt_fall) begin
      rx_shift_d = rx_next;
      idle_d     = '0;
      if (rx_bits_q == 3'd7) begin
        rx_bits_d    = 3'd0;
        rx_data_d    = rx_next;
        rx_valid_d   = 1'b1;
        rx_overrun_d = rx_valid_q & ~rx_ack;
      end else begin
        rx_bits_d = rx_bits_q + 3'd1;
      end
    end else if (rx_bits_q != 3'd0) begin
      if (idle_q == TO_LAST) begin
        rx_bits_d    = 3'd0;
        idle_d       = '0;
        rx_timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  // state registers; lines idle high and synchronizers preset high in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_s1_q     <= 1'b1;
      cnt_s2_q     <= 1'b1;
      cnt_prev_q   <= 1'b1;
      sp_s1_q      <= 1'b1;
      sp_s2_q      <= 1'b1;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      shift_q      <= 8'h00;
      bit_q        <= 3'd0;
      cnt_out_q    <= 1'b1;
      sp_out_q     <= 1'b1;
      rx_shift_q   <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_bits_q    <= 3'd0;
      idle_q       <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      cnt_s1_q     <= cnt_s1_d;
      cnt_s2_q     <= cnt_s2_d;
      cnt_prev_q   <= cnt_prev_d;
      sp_s1_q      <= sp_s1_d;
      sp_s2_q      <= sp_s2_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      cnt_out_q    <= cnt_out_d;
      sp_out_q     <= sp_out_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_bits_q    <= rx_bits_d;
      idle_q       <= idle_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign tx_ready   = (state_q == ST_IDLE) & master;
  assign cnt_out    = cnt_out_q;
  assign sp_out     = sp_out_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_timeout = rx_timeout_q;

endmodule
